// File: rtl/irq_ctrl.sv
// ============================================================================
// Module   : irq_ctrl
// Brief    : Edge-triggered interrupt controller feeding the CPU PC-select
//            path. Rising edges on irq_in latch into a pending register. The
//            highest-numbered pending line that is also unmasked is requested
//            with a 10-bit handler vector. The control unit answers with an
//            ack when it takes the vector and an eoi when the handler returns.
// Option   : IRQ_SYNC_EN - when defined, irq_in passes through a two-flop
//            synchronizer before edge detection. This adds two cycles of
//            event latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_ctrl #(
  parameter int         N_IRQ      = 4,
  parameter logic [9:0] VEC_BASE   = 10'd512,
  parameter int         VEC_STRIDE = 4
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wd,
  input  logic             int_ack,
  input  logic             eoi,
  output logic             int_req,
  output logic [9:0]       int_vec,
  output logic [2:0]       int_id,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending_q,
  output logic [N_IRQ-1:0] mask_q
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  localparam logic [9:0] C_STRIDE = 10'(VEC_STRIDE);

  state_t           state_q, state_d;
  logic             int_req_q, int_req_d;
  logic             in_service_q, in_service_d;
  logic [2:0]       int_id_q, int_id_d;
  logic [9:0]       int_vec_q, int_vec_d;
  logic [N_IRQ-1:0] pending_d;
  logic [N_IRQ-1:0] irq_s_q;
  logic [N_IRQ-1:0] irq_det;
  logic [N_IRQ-1:0] events;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] clr_mask;
  logic [2:0]       win_id;
  logic [9:0]       win_vec;
  logic             ack_clr;

`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer for asynchronous device lines
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_det = sync2_q;
`else
  assign irq_det = irq_in;
`endif

  // A line is an event only on the cycle it is first seen high
  assign events   = irq_det & ~irq_s_q;
  assign eligible = pending_q & mask_q;

  // Highest eligible index wins, and its vector wraps in the 10-bit PC space
  always_comb begin
    win_id = 3'd0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (eligible[i]) win_id = 3'(i);
    end
    win_vec = VEC_BASE + (10'(win_id) * C_STRIDE);
  end

  // Next-state and registered-output logic of the request/service handshake
  always_comb begin
    state_d      = state_q;
    int_req_d    = int_req_q;
    in_service_d = in_service_q;
    int_id_d     = int_id_q;
    int_vec_d    = int_vec_q;
    ack_clr      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|eligible) begin
          int_id_d  = win_id;
          int_vec_d = win_vec;
          int_req_d = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        // Request is frozen until taken. An eoi here is ignored, even when
        // it arrives together with the ack.
        if (int_ack) begin
          ack_clr      = 1'b1;
          int_req_d    = 1'b0;
          in_service_d = 1'b1;
          state_d      = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (eoi) begin
          in_service_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Clear the acknowledged line. A coincident new edge wins over the clear.
  always_comb begin
    clr_mask  = ack_clr ? (N_IRQ'(1) << int_id_q) : '0;
    pending_d = (pending_q & ~clr_mask) | events;
  end

  // State, outputs, pending, mask and edge-sample registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      int_req_q    <= 1'b0;
      in_service_q <= 1'b0;
      int_id_q     <= 3'd0;
      int_vec_q    <= VEC_BASE;
      pending_q    <= '0;
      mask_q       <= '0;
      irq_s_q      <= '0;
    end else begin
      state_q      <= state_d;
      int_req_q    <= int_req_d;
      in_service_q <= in_service_d;
      int_id_q     <= int_id_d;
      int_vec_q    <= int_vec_d;
      pending_q    <= pending_d;
      irq_s_q      <= irq_det;
      if (mask_we) mask_q <= mask_wd;
    end
  end

  assign int_req    = int_req_q;
  assign int_vec    = int_vec_q;
  assign int_id     = int_id_q;
  assign in_service = in_service_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ============================================================================
// Module   : tb_irq_ctrl
// Brief    : Directed self-checking bench for irq_ctrl. It uses a default
//            instance and a second instance with VEC_BASE=1020 to exercise
//            vector wrap-around. Latencies follow IRQ_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] irq, mask_wd;
  logic       mask_we, int_ack, eoi;
  logic       int_req, in_service;
  logic [9:0] int_vec;
  logic [2:0] int_id;
  logic [3:0] pending, mask;

  logic [3:0] b_irq, b_mask_wd;
  logic       b_mask_we, b_ack, b_eoi;
  logic       b_req, b_insvc;
  logic [9:0] b_vec;
  logic [2:0] b_id;
  logic [3:0] b_pend, b_mask;

  int n_vec = 0;
  int n_err = 0;

  irq_ctrl #(.N_IRQ(4), .VEC_BASE(10'd512), .VEC_STRIDE(4)) u_dut (
    .clk(clk), .reset(rst_n), .irq_in(irq), .mask_we(mask_we), .mask_wd(mask_wd),
    .int_ack(int_ack), .eoi(eoi), .int_req(int_req), .int_vec(int_vec),
    .int_id(int_id), .in_service(in_service), .pending_q(pending), .mask_q(mask)
  );

  irq_ctrl #(.N_IRQ(4), .VEC_BASE(10'd1020), .VEC_STRIDE(4)) u_dut_wrap (
    .clk(clk), .reset(rst_n), .irq_in(b_irq), .mask_we(b_mask_we), .mask_wd(b_mask_wd),
    .int_ack(b_ack), .eoi(b_eoi), .int_req(b_req), .int_vec(b_vec),
    .int_id(b_id), .in_service(b_insvc), .pending_q(b_pend), .mask_q(b_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b1; irq = '0; mask_we = 0; mask_wd = '0; int_ack = 0; eoi = 0;
    b_irq = '0; b_mask_we = 0; b_mask_wd = '0; b_ack = 0; b_eoi = 0;
    #2 rst_n = 1'b0;
    tick(2);
    check("rst_req", int_req, 0);
    check("rst_insvc", in_service, 0);
    check("rst_id", int_id, 0);
    check("rst_vec", int_vec, 512);
    check("rst_pend", pending, 0);
    check("rst_mask", mask, 0);
    rst_n = 1'b1;
    tick();

    // Single line 2, mask 0101
    mask_we = 1; mask_wd = 4'b0101; tick(); mask_we = 0;
    check("t1_mask", mask, 4'b0101);
    irq = 4'b0100; tick(LAT);
    check("t1_pend", pending, 4'b0100);
    check("t1_req_early", int_req, 0);
    tick();
    check("t1_req", int_req, 1);
    check("t1_id", int_id, 2);
    check("t1_vec", int_vec, 520);
    int_ack = 1; tick(); int_ack = 0;
    check("t1_ack_pend", pending, 0);
    check("t1_ack_insvc", in_service, 1);
    check("t1_ack_req", int_req, 0);
    eoi = 1; tick(); eoi = 0;
    check("t1_eoi_insvc", in_service, 0);
    tick(2);
    check("t1_hold_pend", pending, 0);
    check("t1_hold_req", int_req, 0);
    irq = '0; tick(LAT + 1);

    // Lines 0 and 2 together: 2 first, then 0
    irq = 4'b0101; tick(LAT);
    check("t2_pend", pending, 4'b0101);
    tick();
    check("t2_id_a", int_id, 2);
    check("t2_vec_a", int_vec, 520);
    eoi = 1; tick(); eoi = 0;
    check("t2_eoi_in_req", int_req, 1);
    int_ack = 1; tick(); int_ack = 0;
    check("t2_pend_a", pending, 4'b0001);
    check("t2_insvc", in_service, 1);
    tick();
    check("t2_no_req_svc", int_req, 0);
    eoi = 1; tick(); eoi = 0;
    check("t2_idle_req", int_req, 0);
    tick();
    check("t2_req_b", int_req, 1);
    check("t2_id_b", int_id, 0);
    check("t2_vec_b", int_vec, 512);
    int_ack = 1; tick(); int_ack = 0;
    eoi = 1; tick(); eoi = 0;
    check("t2_end_pend", pending, 0);
    irq = '0; tick(LAT + 1);

    // Masked line 3 accumulates, then unmasking raises it
    mask_we = 1; mask_wd = 4'b0000; tick(); mask_we = 0;
    irq = 4'b1000; tick(LAT + 2);
    check("t3_pend", pending, 4'b1000);
    check("t3_masked_req", int_req, 0);
    mask_we = 1; mask_wd = 4'b1000; tick(); mask_we = 0;
    tick();
    check("t3_req", int_req, 1);
    check("t3_id", int_id, 3);
    check("t3_vec", int_vec, 524);
    mask_we = 1; mask_wd = 4'b0000; tick(); mask_we = 0;
    check("t3_frozen_req", int_req, 1);
    check("t3_frozen_id", int_id, 3);
    int_ack = 1; eoi = 1; tick(); int_ack = 0; eoi = 0;
    check("t3_ackeoi_insvc", in_service, 1);
    check("t3_ackeoi_pend", pending, 0);
    eoi = 1; tick(); eoi = 0;
    check("t3_eoi", in_service, 0);
    irq = '0; mask_we = 1; mask_wd = 4'b1111; tick(); mask_we = 0;
    tick(LAT + 1);

    // New edge on line 1 coincident with ack: set wins
    irq = 4'b0010; tick(LAT + 1);
    check("t4_req", int_req, 1);
    check("t4_id", int_id, 1);
    check("t4_vec", int_vec, 516);
    irq = '0; tick(LAT + 1);
    irq = 4'b0010;
    if (LAT > 1) tick(LAT - 1);
    int_ack = 1; tick(); int_ack = 0;
    check("t4_set_wins", pending, 4'b0010);
    check("t4_insvc", in_service, 1);
    eoi = 1; tick(); eoi = 0;
    tick();
    check("t4_rereq", int_req, 1);
    check("t4_reid", int_id, 1);
    int_ack = 1; tick(); int_ack = 0;
    eoi = 1; tick(); eoi = 0;
    check("t4_end_pend", pending, 0);

    // Asynchronous reset while in service with pending 0011
    irq = '0; tick(LAT + 1);
    irq = 4'b0011; tick(LAT + 1);
    check("t5_id", int_id, 1);
    int_ack = 1; tick(); int_ack = 0;
    irq = 4'b0001; tick(LAT + 1);
    irq = 4'b0011; tick(LAT);
    check("t5_pend", pending, 4'b0011);
    check("t5_insvc", in_service, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_req", int_req, 0);
    check("t5_rst_insvc", in_service, 0);
    check("t5_rst_id", int_id, 0);
    check("t5_rst_vec", int_vec, 512);
    check("t5_rst_pend", pending, 0);
    check("t5_rst_mask", mask, 0);
    irq = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // Vector wrap: base 1020, line 2 gives 4
    b_mask_we = 1; b_mask_wd = 4'b0100; tick(); b_mask_we = 0;
    b_irq = 4'b0100; tick(LAT);
    check("t6_pend", b_pend, 4'b0100);
    check("t6_req_early", b_req, 0);
    tick();
    check("t6_req", b_req, 1);
    check("t6_id", b_id, 2);
    check("t6_vec_wrap", b_vec, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Edge-triggered interrupt controller that sits directly upstream of the program-counter select path of the single-cycle CPU.
- Latches device interrupt edges into a pending register and filters them through a software-writable mask.
- Selects the highest-numbered unmasked pending line and raises a request with a 10-bit handler vector for the PC mux.
- Handshakes with the control unit: ack on vector fetch, eoi on handler return.

Parameters:
N_IRQ, 4, number of interrupt lines (1..8)
VEC_BASE, 10'd512, handler vector of line 0 (10-bit PC space)
VEC_STRIDE, 4, vector spacing between consecutive lines, in instruction words

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
irq_in  input  N_IRQ  device interrupt lines, level inputs, rising edge is an event
mask_we  input  1  write enable for mask register
mask_wd  input  N_IRQ  mask write data (1 = line enabled)
int_ack  input  1  CPU has taken the vector (one-cycle pulse)
eoi  input  1  end of interrupt, handler returned (one-cycle pulse)
int_req  output  1  interrupt request to control unit
int_vec  output  10  handler address, valid while int_req=1
int_id  output  3  index of the requested or in-service line
in_service  output  1  handler currently executing
pending_q  output  N_IRQ  pending register, readable by software
mask_q  output  N_IRQ  mask register

Behaviour:
- Reset (reset=0, asynchronous):
  - int_req=0, in_service=0, int_id=0, int_vec=VEC_BASE.
  - pending_q=0, mask_q=0, edge-sample register=0, FSM=IDLE.
  - Reset asserted mid-handshake aborts everything; no pending state survives.
- Edge detect:
  - irq_s register samples irq_in every clock.
  - Event on line i at a posedge where irq_in[i]=1 and irq_s[i]=0.
  - The event sets pending_q[i] at that same edge, so it is visible one cycle after the line rises.
  - A line held high produces exactly one event.
  - Events are latched regardless of mask.
- Mask:
  - mask_q <= mask_wd on a posedge with mask_we=1.
  - Masked lines keep accumulating pending bits.
  - Unmasking a pending line makes it eligible on the next cycle.
- Priority: among (pending_q & mask_q), the highest index wins.
- Vector: int_vec = VEC_BASE + int_id*VEC_STRIDE, computed modulo 1024 (wraps in the 10-bit PC space).
- FSM, all outputs registered:
  - IDLE: if any eligible bit, latch int_id = winner, int_req<=1, go to REQ. Otherwise stay.
  - REQ: int_id and int_vec are frozen. Mask changes or new higher-priority events do not retract or replace the request. On int_ack=1: clear pending_q[int_id], int_req<=0, in_service<=1, go to SERVICE.
  - SERVICE: no new request is raised and events continue to latch. On eoi=1: in_service<=0, go to IDLE. The next request can assert at the earliest one cycle later (IDLE evaluates first).
- Simultaneous events:
  - A new edge on line int_id in the same cycle as int_ack: set wins, so the pending bit stays 1 and the line is serviced again after eoi.
  - int_ack outside REQ is ignored.
  - eoi outside SERVICE is ignored.
  - int_ack and eoi together in REQ: only ack acts.
- Latency, single unmasked line from a rising edge:
  - pending_q at +1 cycle.
  - int_req at +2 cycles.

Optional Feature:
IRQ_SYNC_EN
- Defined: irq_in first passes through a two-flop synchronizer (both stages reset to 0) before edge detection. Event-to-pending latency becomes 3 cycles; int_req asserts at +4. Use for asynchronous device lines.
- Undefined: irq_in feeds edge detection directly, with the latencies stated in Behaviour.

Test Plan:
- Reset, then mask_wd=4'b0101 written, irq_in[2] rises -> pending_q=4'b0100 at +1, int_req=1 with int_id=2 and int_vec=520 at +2; int_ack -> pending_q=0, in_service=1; eoi -> in_service=0, FSM returns to IDLE.
- irq_in[0] and irq_in[2] rise in the same cycle with mask=4'b0101 -> line 2 serviced first (vec 520); after eoi, line 0 requested with vec 512.
- mask=0, irq_in[3] rises -> pending_q=4'b1000 and int_req stays 0; write mask=4'b1000 -> int_req=1 next cycle, int_id=3, int_vec=524.
- In REQ for line 1, irq_in[1] produces a new edge in the int_ack cycle -> pending_q[1] stays 1; after eoi, line 1 is requested again.
- Pull reset low while in SERVICE with pending_q=4'b0011 -> all outputs return to reset values immediately, without waiting for a clock edge.
- VEC_BASE=1020, VEC_STRIDE=4, line 2 requested -> int_vec=4 (wrap-around); with IRQ_SYNC_EN defined, int_req asserts 4 cycles after the edge.
